video_pll_lock_supervisor: RTL and testbench

Supervises the video PLL lock indication in the reference-clock domain.
- Drives the PLL reset input.
- Qualifies the PLL `locked` output with a stability window.
- Holds downstream video logic in reset until lock is qualified.
- Retries PLL acquisition on timeout and reports status.
- Sits between the video PLL wrapper and the video pipeline/reset tree.

---
 rtl/video_pll_lock_supervisor.sv | 166 ++++++++++++++++
 tb/tb_video_pll_lock_supervisor.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_pll_lock_supervisor.sv
// video_pll_lock_supervisor
// Supervises the video PLL lock indication in the reference-clock domain.
// It drives the PLL reset, qualifies the lock with a stability window and
// holds the video pipeline in reset until the lock has been qualified.
// Optional feature macro: VIDEO_PLL_SUP_RELOCK_EN
//   defined   -> a lock loss in RUN restarts PLL acquisition
//   undefined -> a lock loss in RUN is fatal (FAIL until rst)
// The stability window is exact for LOCK_STABLE_CYCLES >= 2. The WAIT_LOCK
// cycle that first sees lock counts as the first cycle of the window.
module video_pll_lock_supervisor #(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES         = 4
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       video_rst,
  output logic       lock_ok,
  output logic       lock_fail,
  output logic [3:0] retry_count,
  output logic [7:0] lost_lock_count
);

  localparam int MAX_AB  = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ? PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int MAX_ABC = (MAX_AB > LOCK_STABLE_CYCLES) ? MAX_AB : LOCK_STABLE_CYCLES;
  localparam int CNT_W   = $clog2(MAX_ABC) + 1;

  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  =
    CNT_W'((LOCK_STABLE_CYCLES >= 2) ? (LOCK_STABLE_CYCLES - 2) : 0);
  localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_PLL_RESET = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_t;

  logic             lock_meta_reg;
  logic             lock_s_reg;
  state_t           state_reg,  state_next;
  logic [CNT_W-1:0] cnt_reg,    cnt_next;
  logic [3:0]       retry_reg,  retry_next;
  logic [3:0]       retry_inc;
  logic [7:0]       lost_reg,   lost_next;
  logic             pll_rst_reg,   pll_rst_next;
  logic             video_rst_reg, video_rst_next;
  logic             lock_ok_reg,   lock_ok_next;
  logic             lock_fail_reg, lock_fail_next;

  // Two-flop synchronizer bringing the asynchronous PLL lock into refclk.
  always_ff @(posedge refclk) begin
    if (rst) begin
      lock_meta_reg <= 1'b0;
      lock_s_reg    <= 1'b0;
    end else begin
      lock_meta_reg <= pll_locked;
      lock_s_reg    <= lock_meta_reg;
    end
  end

  // State, shared cycle counter and status counters.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_reg <= ST_PLL_RESET;
      cnt_reg   <= '0;
      retry_reg <= 4'd0;
      lost_reg  <= 8'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      retry_reg <= retry_next;
      lost_reg  <= lost_next;
    end
  end

  // Next-state, counter and status-counter logic.
  always_comb begin
    state_next = state_reg;
    retry_next = retry_reg;
    lost_next  = lost_reg;
    retry_inc  = (retry_reg == 4'hF) ? retry_reg : retry_reg + 4'd1;
    case (state_reg)
      ST_PLL_RESET: begin
        // Lock is deliberately ignored while the PLL is held in reset.
        if (cnt_reg == RST_LAST) state_next = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        // A lock seen on the timeout cycle wins over the retry.
        if (lock_s_reg) begin
          state_next = ST_STABLE;
        end else if (cnt_reg == TIMEOUT_LAST) begin
          retry_next = retry_inc;
          if ((MAX_RETRIES != 0) && (retry_inc == RETRY_LIMIT)) state_next = ST_FAIL;
          else                                                  state_next = ST_PLL_RESET;
        end
      end
      ST_STABLE: begin
        if (!lock_s_reg) begin
          state_next = ST_WAIT_LOCK;
        end else if (cnt_reg >= STABLE_LAST) begin
          state_next = ST_RUN;
          retry_next = 4'd0;
        end
      end
      ST_RUN: begin
        if (!lock_s_reg) begin
          lost_next = (lost_reg == 8'hFF) ? lost_reg : lost_reg + 8'd1;
`ifdef VIDEO_PLL_SUP_RELOCK_EN
          state_next = ST_PLL_RESET;
`else
          state_next = ST_FAIL;
`endif
        end
      end
      ST_FAIL: state_next = ST_FAIL;
      default: state_next = ST_PLL_RESET;
    endcase

    // Counter restarts on every state entry; it only advances in timed states.
    if (state_next != state_reg)
      cnt_next = '0;
    else if ((state_reg == ST_PLL_RESET) || (state_reg == ST_WAIT_LOCK) || (state_reg == ST_STABLE))
      cnt_next = cnt_reg + CNT_ONE;
    else
      cnt_next = cnt_reg;
  end

  // Output decode from the state being entered, so registered outputs track the state.
  always_comb begin
    pll_rst_next   = (state_next == ST_PLL_RESET) || (state_next == ST_FAIL);
    video_rst_next = (state_next != ST_RUN);
    lock_ok_next   = (state_next == ST_RUN);
    lock_fail_next = (state_next == ST_FAIL);
  end

  // Output registers.
  always_ff @(posedge refclk) begin
    if (rst) begin
      pll_rst_reg   <= 1'b1;
      video_rst_reg <= 1'b1;
      lock_ok_reg   <= 1'b0;
      lock_fail_reg <= 1'b0;
    end else begin
      pll_rst_reg   <= pll_rst_next;
      video_rst_reg <= video_rst_next;
      lock_ok_reg   <= lock_ok_next;
      lock_fail_reg <= lock_fail_next;
    end
  end

  assign pll_rst         = pll_rst_reg;
  assign video_rst       = video_rst_reg;
  assign lock_ok         = lock_ok_reg;
  assign lock_fail       = lock_fail_reg;
  assign retry_count     = retry_reg;
  assign lost_lock_count = lost_reg;

endmodule

// File: tb/tb_video_pll_lock_supervisor.sv
// tb_video_pll_lock_supervisor
// Directed scenarios with hand-computed cycle expectations, then randomized
// lock/reset stimulus checked every cycle against a timeline model.
// Follows VIDEO_PLL_SUP_RELOCK_EN the same way the design does.
module tb_video_pll_lock_supervisor;

  localparam int PRC = 4;
  localparam int TO  = 32;
  localparam int LSC = 8;
  localparam int MR  = 2;

  localparam int P_RST    = 0;
  localparam int P_WAIT   = 1;
  localparam int P_STABLE = 2;
  localparam int P_RUN    = 3;
  localparam int P_FAIL   = 4;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       pll_rst, video_rst, lock_ok, lock_fail;
  logic [3:0] retry_count;
  logic [7:0] lost_lock_count;

  always #5 refclk = ~refclk;

  video_pll_lock_supervisor #(
    .PLL_RST_CYCLES(PRC), .LOCK_TIMEOUT_CYCLES(TO),
    .LOCK_STABLE_CYCLES(LSC), .MAX_RETRIES(MR)
  ) dut (
    .refclk(refclk), .rst(rst), .pll_locked(pll_locked),
    .pll_rst(pll_rst), .video_rst(video_rst), .lock_ok(lock_ok),
    .lock_fail(lock_fail), .retry_count(retry_count),
    .lost_lock_count(lost_lock_count)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_printed = 0;
  int cyc = 0;
  bit model_en = 1'b0;

  // Timeline model: phase, time spent in it, run length of synchronized lock.
  int m_phase = P_RST;
  int m_elapsed = 0;
  int m_lockrun = 0;
  int m_retries = 0;
  int m_losses = 0;
  bit m_h1 = 1'b0;
  bit m_h2 = 1'b0;

  task automatic model_step();
    bit ls;
    int nxt;
    if (rst) begin
      m_phase = P_RST; m_elapsed = 0; m_lockrun = 0;
      m_retries = 0; m_losses = 0; m_h1 = 1'b0; m_h2 = 1'b0;
    end else begin
      ls = m_h2;            // lock as seen two clocks after the pin
      m_h2 = m_h1;
      m_h1 = pll_locked;
      nxt = m_phase;
      if (m_phase == P_WAIT || m_phase == P_STABLE) m_lockrun = ls ? m_lockrun + 1 : 0;
      else m_lockrun = 0;
      case (m_phase)
        P_RST:  if (m_elapsed + 1 >= PRC) nxt = P_WAIT;
        P_WAIT: begin
          if (ls) nxt = P_STABLE;
          else if (m_elapsed + 1 >= TO) begin
            m_retries = (m_retries < 15) ? m_retries + 1 : 15;
            nxt = (MR != 0 && m_retries == MR) ? P_FAIL : P_RST;
          end
        end
        P_STABLE: begin
          if (!ls) nxt = P_WAIT;
          else if (m_lockrun >= LSC) begin nxt = P_RUN; m_retries = 0; end
        end
        P_RUN: begin
          if (!ls) begin
            m_losses = (m_losses < 255) ? m_losses + 1 : 255;
`ifdef VIDEO_PLL_SUP_RELOCK_EN
            nxt = P_RST;
`else
            nxt = P_FAIL;
`endif
          end
        end
        default: nxt = m_phase;
      endcase
      m_elapsed = (nxt != m_phase) ? 0 : m_elapsed + 1;
      m_phase = nxt;
    end
  endtask

  task automatic cmp(string nm, int got, int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      if (n_printed < 40) begin
        n_printed++;
        $display("FAIL %s at t=%0t: got %0d, expected %0d", nm, $time, got, exp);
      end
    end
  endtask

  task automatic chk(string nm, int got, int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, got, exp);
    end else begin
      $display("check %s at cycle %0d: %0d ok", nm, cyc, got);
    end
  endtask

  initial forever begin
    @(posedge refclk);
    model_step();
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge refclk);
    if (model_en) begin
      cmp("model_pll_rst",   int'(pll_rst),   int'(m_phase == P_RST || m_phase == P_FAIL));
      cmp("model_video_rst", int'(video_rst), int'(m_phase != P_RUN));
      cmp("model_lock_ok",   int'(lock_ok),   int'(m_phase == P_RUN));
      cmp("model_lock_fail", int'(lock_fail), int'(m_phase == P_FAIL));
      cmp("model_retry",     int'(retry_count),     m_retries);
      cmp("model_lost",      int'(lost_lock_count), m_losses);
    end
  end

  task automatic step(int n);
    repeat (n) begin
      @(posedge refclk);
      #1;
      cyc++;
    end
  endtask

  task automatic goto(int c);
    while (cyc < c) step(1);
  endtask

  // Leaves the bench in cycle 0: the first cycle after rst is sampled low... next edge.
  task automatic start();
    @(posedge refclk);
    #1;
    rst = 1'b1;
    pll_locked = 1'b0;
    step(2);
    rst = 1'b0;
    cyc = 0;
  endtask

  initial begin
    #200000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge refclk);
    #1;
    model_en = 1'b1;

    // Bring-up.
    start();
    chk("s1_reset_pll_rst", int'(pll_rst), 1);
    chk("s1_reset_video_rst", int'(video_rst), 1);
    chk("s1_reset_lock_ok", int'(lock_ok), 0);
    chk("s1_reset_lock_fail", int'(lock_fail), 0);
    chk("s1_reset_retry", int'(retry_count), 0);
    chk("s1_reset_lost", int'(lost_lock_count), 0);
    goto(3);  chk("s1_pll_rst_c3", int'(pll_rst), 1);
    goto(4);  chk("s1_pll_rst_c4", int'(pll_rst), 0);
    goto(10); pll_locked = 1'b1;
    goto(19); chk("s1_video_rst_c19", int'(video_rst), 1);
    goto(20); chk("s1_video_rst_c20", int'(video_rst), 0);
    chk("s1_lock_ok_c20", int'(lock_ok), 1);
    chk("s1_retry_c20", int'(retry_count), 0);

    // Loss in RUN at L=30.
    goto(30); pll_locked = 1'b0;
    goto(32); chk("s4_video_rst_L2", int'(video_rst), 0);
    goto(33); chk("s4_video_rst_L3", int'(video_rst), 1);
    chk("s4_lock_ok_L3", int'(lock_ok), 0);
    chk("s4_lost_L3", int'(lost_lock_count), 1);
`ifdef VIDEO_PLL_SUP_RELOCK_EN
    chk("s4_pll_rst_L3", int'(pll_rst), 1);
    goto(36); chk("s4_pll_rst_L6", int'(pll_rst), 1);
    goto(37); chk("s4_pll_rst_L7", int'(pll_rst), 0);
    goto(40); pll_locked = 1'b1;
    goto(49); chk("s4_video_rst_R9", int'(video_rst), 1);
    goto(50); chk("s4_video_rst_R10", int'(video_rst), 0);
    chk("s4_lock_ok_R10", int'(lock_ok), 1);
`else
    chk("s6_lock_fail_L3", int'(lock_fail), 1);
    chk("s6_pll_rst_L3", int'(pll_rst), 1);
    goto(40); pll_locked = 1'b1;
    goto(60); chk("s6_lock_fail_hold", int'(lock_fail), 1);
    chk("s6_video_rst_hold", int'(video_rst), 1);
    chk("s6_lock_ok_hold", int'(lock_ok), 0);
    chk("s6_lost_hold", int'(lost_lock_count), 1);
`endif

    // Glitchy lock: high 10-14, low 15, steady from T=16.
    start();
    goto(10); pll_locked = 1'b1;
    goto(15); pll_locked = 1'b0;
    goto(16); pll_locked = 1'b1;
    goto(25); chk("s2_video_rst_T9", int'(video_rst), 1);
    goto(26); chk("s2_video_rst_T10", int'(video_rst), 0);
    chk("s2_retry", int'(retry_count), 0);

    // No lock: two timeouts then FAIL.
    start();
    goto(35); chk("s3_pll_rst_c35", int'(pll_rst), 0);
    goto(36); chk("s3_pll_rst_c36", int'(pll_rst), 1);
    chk("s3_retry_c36", int'(retry_count), 1);
    goto(39); chk("s3_pll_rst_c39", int'(pll_rst), 1);
    goto(40); chk("s3_pll_rst_c40", int'(pll_rst), 0);
    goto(71); chk("s3_lock_fail_c71", int'(lock_fail), 0);
    goto(72); chk("s3_lock_fail_c72", int'(lock_fail), 1);
    chk("s3_retry_c72", int'(retry_count), 2);
    goto(100); chk("s3_pll_rst_stuck", int'(pll_rst), 1);
    chk("s3_video_rst_stuck", int'(video_rst), 1);

    // Reset mid-STABLE after one timeout (STABLE entered at cycle 43).
    start();
    goto(40); pll_locked = 1'b1;
    goto(45); chk("s5_retry_before", int'(retry_count), 1);
    chk("s5_pll_rst_before", int'(pll_rst), 0);
    rst = 1'b1;
    goto(46); chk("s5_pll_rst", int'(pll_rst), 1);
    chk("s5_video_rst", int'(video_rst), 1);
    chk("s5_lock_ok", int'(lock_ok), 0);
    chk("s5_retry", int'(retry_count), 0);
    rst = 1'b0;

    // Randomized lock segments with occasional reset pulses.
    start();
    for (int seg = 0; seg < 150; seg++) begin
      int len;
      if ($urandom_range(0, 15) == 0) begin
        rst = 1'b1;
        step(int'($urandom_range(1, 3)));
        rst = 1'b0;
      end
      pll_locked = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 40));
      step(len);
      $display("seg %0d: pll_locked=%0d for %0d cycles -> lock_ok=%0d lock_fail=%0d retry=%0d lost=%0d",
               seg, pll_locked, len, lock_ok, lock_fail, retry_count, lost_lock_count);
    end

    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
